// File: rtl/sata_cmdfis_pkg.sv
// ============================================================================
// sata_cmdfis_pkg : shared SATA FIS constants, state encoding and command record
// Rev 1.0
// ============================================================================
`default_nettype none

package sata_cmdfis_pkg;

  localparam logic [7:0] FIS_REG_H2D = 8'h27;
  localparam logic [7:0] FIS_REG_D2H = 8'h34;

  localparam int STATUS_ERR = 0;
  localparam int STATUS_BSY = 7;

  localparam logic [2:0] LAST_DW = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  command;
    logic [15:0] features;
    logic [47:0] lba;
    logic [15:0] count;
    logic [7:0]  device;
    logic [7:0]  icc;
    logic [7:0]  control;
    logic [3:0]  pmport;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/sata_cmdfis_if.sv
// ============================================================================
// sata_cmdfis_if : command fields, H2D/D2H FIS streams and completion status
// Rev 1.0
// ============================================================================
`default_nettype none

interface sata_cmdfis_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_command;
  logic [15:0] i_features;
  logic [47:0] i_lba;
  logic [15:0] i_count;
  logic [7:0]  i_device;
  logic [7:0]  i_icc;
  logic [7:0]  i_control;
  logic [3:0]  i_pmport;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_abort;

  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_timeout;
  logic [7:0]  o_status;
  logic [7:0]  o_error;

  // Command issuer side
  modport slave (
    input  i_cmd_valid, i_command, i_features, i_lba, i_count,
           i_device, i_icc, i_control, i_pmport,
    output o_cmd_ready,
    output m_valid, m_data, m_last,
    input  m_ready,
    input  s_valid, s_data, s_last, s_abort,
    output o_busy, o_done, o_err, o_timeout, o_status, o_error
  );

  // Host / link side
  modport master (
    output i_cmd_valid, i_command, i_features, i_lba, i_count,
           i_device, i_icc, i_control, i_pmport,
    input  o_cmd_ready,
    input  m_valid, m_data, m_last,
    output m_ready,
    output s_valid, s_data, s_last, s_abort,
    input  o_busy, o_done, o_err, o_timeout, o_status, o_error
  );
endinterface

`default_nettype wire

// File: rtl/sata_cmdfis.sv
// ============================================================================
// sata_cmdfis : issues a Register H2D FIS and waits for the Register D2H reply
// Rev 1.0
// ============================================================================
`default_nettype none

module sata_cmdfis #(
  parameter int LGTIMEOUT = 20
) (
  input  wire logic     i_clk,
  input  wire logic     i_reset_n,
  sata_cmdfis_if.slave  bus
);
  import sata_cmdfis_pkg::*;

  state_t                r_state;
  logic [2:0]            r_idx;
  cmd_t                  r_cmd;
  logic [LGTIMEOUT-1:0]  r_timer;
  logic                  r_frame_start;
  logic                  r_matched;
  logic [7:0]            r_pend_status;
  logic [7:0]            r_pend_error;

  cmd_t                  w_cmd_in;
  logic                  w_type_ok;
  logic                  w_matched;
  logic [7:0]            w_status;
  logic [7:0]            w_error;
  logic                  w_complete;
  logic [LGTIMEOUT-1:0]  w_timer_next;
  logic                  w_expire;
  logic                  w_tx_hs;
  logic                  w_unused_rx;

  function automatic logic [31:0] fis_word(input logic [2:0] idx, input cmd_t c);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {c.features[7:0], c.command, {1'b1, 3'b000, c.pmport}, FIS_REG_H2D};
      3'd1:    w = {c.device, c.lba[23:0]};
      3'd2:    w = {c.features[15:8], c.lba[47:24]};
      3'd3:    w = {c.control, c.icc, c.count};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always_comb begin
    w_cmd_in          = '0;
    w_cmd_in.command  = bus.i_command;
    w_cmd_in.features = bus.i_features;
    w_cmd_in.lba      = bus.i_lba;
    w_cmd_in.count    = bus.i_count;
    w_cmd_in.device   = bus.i_device;
    w_cmd_in.icc      = bus.i_icc;
    w_cmd_in.control  = bus.i_control;
    w_cmd_in.pmport   = bus.i_pmport;
  end

  // A single-word D2H frame must complete from the word on the bus, not the pending copy.
  assign w_type_ok    = (bus.s_data[7:0] == FIS_REG_D2H);
  assign w_matched    = r_frame_start ? w_type_ok : r_matched;
  assign w_status     = (r_frame_start && w_type_ok) ? bus.s_data[23:16] : r_pend_status;
  assign w_error      = (r_frame_start && w_type_ok) ? bus.s_data[31:24] : r_pend_error;
  assign w_complete   = bus.s_valid && bus.s_last && !bus.s_abort && w_matched;
  assign w_timer_next = r_timer - 1'b1;
  assign w_expire     = (w_timer_next == '0);
  assign w_tx_hs      = bus.m_valid && bus.m_ready;
  assign w_unused_rx  = ^bus.s_data[15:8];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= ST_IDLE;
      r_idx           <= 3'd0;
      r_cmd           <= '0;
      r_timer         <= '0;
      r_frame_start   <= 1'b0;
      r_matched       <= 1'b0;
      r_pend_status   <= 8'h0;
      r_pend_error    <= 8'h0;
      bus.o_cmd_ready <= 1'b1;
      bus.m_valid     <= 1'b0;
      bus.m_data      <= 32'h0;
      bus.m_last      <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_done      <= 1'b0;
      bus.o_err       <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_status    <= 8'h0;
      bus.o_error     <= 8'h0;
    end else begin
      bus.o_done    <= 1'b0;
      bus.o_err     <= 1'b0;
      bus.o_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_cmd_valid) begin
            r_cmd           <= w_cmd_in;
            r_idx           <= 3'd0;
            bus.m_valid     <= 1'b1;
            bus.m_data      <= fis_word(3'd0, w_cmd_in);
            bus.m_last      <= 1'b0;
            bus.o_cmd_ready <= 1'b0;
            bus.o_busy      <= 1'b1;
            r_state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_tx_hs) begin
            if (r_idx == LAST_DW) begin
              bus.m_valid   <= 1'b0;
              bus.m_last    <= 1'b0;
              bus.m_data    <= 32'h0;
              r_timer       <= '1;
              r_frame_start <= 1'b1;
              r_matched     <= 1'b0;
              r_state       <= ST_WAIT;
            end else begin
              r_idx      <= r_idx + 3'd1;
              bus.m_data <= fis_word(r_idx + 3'd1, r_cmd);
              bus.m_last <= ((r_idx + 3'd1) == LAST_DW);
            end
          end
        end
        ST_WAIT: begin
          r_timer <= w_timer_next;
          if (bus.s_valid) begin
            if (r_frame_start) begin
              r_frame_start <= 1'b0;
              r_matched     <= w_type_ok;
              if (w_type_ok) begin
                r_pend_status <= bus.s_data[23:16];
                r_pend_error  <= bus.s_data[31:24];
              end
            end
            if (bus.s_abort || (bus.s_last && !w_matched)) begin
              r_frame_start <= 1'b1;
            end
          end
          // Completion takes priority over a timeout landing on the same cycle.
          if (w_complete) begin
            bus.o_status    <= w_status;
            bus.o_error     <= w_error;
            bus.o_done      <= 1'b1;
            bus.o_err       <= w_status[STATUS_ERR] | w_status[STATUS_BSY];
            bus.o_cmd_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
            r_state         <= ST_IDLE;
          end else if (w_expire) begin
            bus.o_done      <= 1'b1;
            bus.o_err       <= 1'b1;
            bus.o_timeout   <= 1'b1;
            bus.o_cmd_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
